// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase req/ack link bridges.
// Holds the responder FSM state type and the default link geometry.
package hs_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } rx_state_t;

    localparam int HS_DW    = 8;
    localparam int HS_DEPTH = 4;

endpackage

// File: rtl/hs_rx_fifo.sv
// Synchronous show-ahead FIFO: dout is always the head word.
// Ports: clk, rst (sync, active-high), din/wen write side with full,
//        ren/empty/dout read side, count = current occupancy.
module hs_rx_fifo import hs_pkg::*; #(
    parameter int DW    = HS_DW,
    parameter int DEPTH = HS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              din,
    input  logic                       wen,
    output logic                       full,
    input  logic                       ren,
    output logic                       empty,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt_q;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come straight from the registered count, so they never glitch.
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem[rptr];

    // Defensive qualification; the bridge never asks for either case.
    assign wr_ok = wen & ~full;
    assign rd_ok = ren & ~empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/handshake_rx_bridge.sv
// Responder end of the 4-phase req/ack link, re-emitted as valid/ready.
// Ports: clk, rst (sync, active-high), req/data_i/ack link side,
//        data_o/valid/ready stream side, level = FIFO occupancy.
module handshake_rx_bridge import hs_pkg::*; #(
    parameter int DW          = HS_DW,
    parameter int DEPTH       = HS_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [DW-1:0]              data_i,
    output logic                       ack,
    output logic [DW-1:0]              data_o,
    output logic                       valid,
    input  logic                       ready,
    output logic [$clog2(DEPTH):0]     level
);

    logic            req_s;
    rx_state_t       state_q;
    rx_state_t       state_d;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_head;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= req;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A capture only happens from IDLE, and IDLE is only re-entered
    // once req_s has dropped, so a held req can never push twice.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && !fifo_full) begin
                    push    = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack     <= 1'b0;
        end else begin
            state_q <= state_d;
            ack     <= (state_d == ACK_HI);
        end
    end

    assign valid  = ~fifo_empty;
    assign pop    = valid & ready;
    assign data_o = valid ? fifo_head : '0;

    hs_rx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (data_i),
        .wen   (push),
        .full  (fifo_full),
        .ren   (pop),
        .empty (fifo_empty),
        .dout  (fifo_head),
        .count (level)
    );

endmodule

// File: tb/tb_handshake_rx_bridge.sv
// Directed bench for handshake_rx_bridge.
// Two instances: SYNC_STAGES=2 (main) and SYNC_STAGES=0.
module tb_handshake_rx_bridge;

    logic       clk;
    logic       rst;

    logic       req;
    logic [7:0] data_i;
    logic       ack;
    logic [7:0] data_o;
    logic       valid;
    logic       ready;
    logic [2:0] level;

    logic       req0;
    logic [7:0] data_i0;
    logic       ack0;
    logic [7:0] data_o0;
    logic       valid0;
    logic       ready0;
    logic [2:0] level0;

    int nchk;
    int nerr;

    logic       cap_en;
    logic       tog_en;
    logic [7:0] cap_q[$];
    int         max_lvl;
    int         ovf_cnt;
    int         gate_err;

    handshake_rx_bridge #(
        .DW          (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data_i (data_i),
        .ack    (ack),
        .data_o (data_o),
        .valid  (valid),
        .ready  (ready),
        .level  (level)
    );

    handshake_rx_bridge #(
        .DW          (8),
        .DEPTH       (4),
        .SYNC_STAGES (0)
    ) dut0 (
        .clk    (clk),
        .rst    (rst),
        .req    (req0),
        .data_i (data_i0),
        .ack    (ack0),
        .data_o (data_o0),
        .valid  (valid0),
        .ready  (ready0),
        .level  (level0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (cap_en && valid && ready) begin
            cap_q.push_back(data_o);
        end
        if (int'(level) > max_lvl) begin
            max_lvl <= int'(level);
        end
        if (level > 3'd4 || level0 > 3'd4) begin
            ovf_cnt <= ovf_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if ((!valid && data_o != 8'h00) || (!valid0 && data_o0 != 8'h00)) begin
            gate_err <= gate_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n;
        n = 0;
        while (ack !== v && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ack}, {31'd0, v});
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        data_i = d;
        req    = 1'b1;
        wait_ack(1'b1, {tag, "_up"});
        req = 1'b0;
        wait_ack(1'b0, {tag, "_dn"});
    endtask

    initial begin
        nchk     = 0;
        nerr     = 0;
        cap_en   = 1'b0;
        tog_en   = 1'b0;
        max_lvl  = 0;
        ovf_cnt  = 0;
        gate_err = 0;
        rst      = 1'b1;
        req      = 1'b0;
        data_i   = 8'h00;
        ready    = 1'b0;
        req0     = 1'b0;
        data_i0  = 8'h00;
        ready0   = 1'b0;

        tick();
        tick();
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data",  {24'd0, data_o}, 32'd0);
        chk("rst_level", {29'd0, level},  32'd0);
        rst = 1'b0;

        // Scenario 1: single transfer, SYNC_STAGES=2
        data_i = 8'hA5;
        req    = 1'b1;
        tick();
        tick();
        chk("s1_ack_early", {31'd0, ack}, 32'd0);
        tick();
        chk("s1_ack_rise",  {31'd0, ack}, 32'd1);
        tick();
        chk("s1_valid",     {31'd0, valid}, 32'd1);
        chk("s1_data",      {24'd0, data_o}, 32'hA5);
        chk("s1_level",     {29'd0, level},  32'd1);
        req = 1'b0;
        tick();
        tick();
        chk("s1_ack_hold",  {31'd0, ack}, 32'd1);
        tick();
        chk("s1_ack_fall",  {31'd0, ack}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s1_pop_valid", {31'd0, valid}, 32'd0);
        chk("s1_pop_data",  {24'd0, data_o}, 32'h00);
        chk("s1_pop_level", {29'd0, level},  32'd0);

        // Scenario 2: fill, back-pressure, release
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), "s2_send");
        end
        chk("s2_full_level", {29'd0, level}, 32'd4);
        data_i = 8'h05;
        req    = 1'b1;
        repeat (10) tick();
        chk("s2_full_noack", {31'd0, ack}, 32'd0);
        chk("s2_head",       {24'd0, data_o}, 32'h01);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s2_pop_level", {29'd0, level}, 32'd3);
        wait_ack(1'b1, "s2_ack5_up");
        chk("s2_refill",    {29'd0, level}, 32'd4);
        req = 1'b0;
        wait_ack(1'b0, "s2_ack5_dn");
        ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("s2_order", {24'd0, data_o}, i);
            tick();
        end
        ready = 1'b0;
        chk("s2_drained", {31'd0, valid}, 32'd0);

        // Scenario 3: held req produces one push
        data_i = 8'h3C;
        req    = 1'b1;
        wait_ack(1'b1, "s3_up");
        repeat (20) tick();
        chk("s3_ack_held", {31'd0, ack},   32'd1);
        chk("s3_level",    {29'd0, level}, 32'd1);
        req = 1'b0;
        wait_ack(1'b0, "s3_dn");
        chk("s3_single",   {29'd0, level},  32'd1);
        chk("s3_data",     {24'd0, data_o}, 32'h3C);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("s3_empty",    {29'd0, level}, 32'd0);

        // Scenario 4: 8 transfers with toggling ready
        cap_q.delete();
        cap_en = 1'b1;
        tog_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(8'h10 + 8'(i), "s4_send");
                end
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    ready = ~ready;
                    tick();
                end
            end
        join
        ready = 1'b1;
        for (int n = 0; n < 20 && valid; n++) begin
            tick();
        end
        ready  = 1'b0;
        cap_en = 1'b0;
        chk("s4_count", cap_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("s4_order",
                (i < cap_q.size()) ? {24'd0, cap_q[i]} : 32'hFFFF,
                32'h10 + i);
        end
        chk("s4_maxlvl", {31'd0, max_lvl > 4}, 32'd0);

        // Scenario 5: reset while in ACK_HI with two words queued
        send(8'h50, "s5_send");
        data_i = 8'h51;
        req    = 1'b1;
        wait_ack(1'b1, "s5_up");
        chk("s5_level2", {29'd0, level}, 32'd2);
        data_i = 8'h44;
        rst    = 1'b1;
        tick();
        chk("s5_rst_ack",   {31'd0, ack},    32'd0);
        chk("s5_rst_valid", {31'd0, valid},  32'd0);
        chk("s5_rst_data",  {24'd0, data_o}, 32'd0);
        chk("s5_rst_level", {29'd0, level},  32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("s5_ack_early", {31'd0, ack}, 32'd0);
        tick();
        chk("s5_recapture", {31'd0, ack},   32'd1);
        chk("s5_level1",    {29'd0, level}, 32'd1);
        tick();
        chk("s5_data",      {24'd0, data_o}, 32'h44);
        req = 1'b0;
        wait_ack(1'b0, "s5_dn");
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Scenario 6: SYNC_STAGES=0 instance
        data_i0 = 8'hA5;
        req0    = 1'b1;
        chk("s6_ack_pre",  {31'd0, ack0}, 32'd0);
        tick();
        chk("s6_ack_rise", {31'd0, ack0}, 32'd1);
        tick();
        chk("s6_valid",    {31'd0, valid0},  32'd1);
        chk("s6_data",     {24'd0, data_o0}, 32'hA5);
        req0 = 1'b0;
        tick();
        chk("s6_ack_fall", {31'd0, ack0}, 32'd0);
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        chk("s6_pop_valid", {31'd0, valid0}, 32'd0);
        chk("s6_pop_level", {29'd0, level0}, 32'd0);

        chk("no_overflow",  ovf_cnt,  32'd0);
        chk("zero_gating",  gate_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
